// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounced press/release, key index, hold level and press strobe.
// Optional auto-repeat of key_pulse while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [3:0] posicion,
    output logic       opr,
    output logic       key_pulse
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_err
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    state_e           state_q;
    logic [3:0]       fila_m_q;
    logic [3:0]       fila_s_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [3:0]       cand_q;
    logic [3:0]       deb_cnt_q;
    logic [3:0]       rel_cnt_q;
    logic [3:0]       posicion_q;
    logic             opr_q;
    logic             key_pulse_q;

    logic             tick;
    logic             hit;
    logic [1:0]       row_idx;
    logic             cand_down;
    logic [3:0]       deb_cnt_d;
    logic [3:0]       rel_cnt_d;

    assign tick      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign cand_down = ~fila_s_q[cand_q[3:2]];
    assign deb_cnt_d = (deb_cnt_q == 4'hF) ? 4'hF : deb_cnt_q + 4'd1;
    assign rel_cnt_d = (rel_cnt_q == 4'hF) ? 4'hF : rel_cnt_q + 4'd1;

    // Lowest-numbered low row wins when several rows are pulled down.
    always_comb begin
        hit     = (fila_s_q != 4'hF);
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!fila_s_q[i]) row_idx = 2'(i);
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    assign rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            fila_m_q    <= 4'hF;
            fila_s_q    <= 4'hF;
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            cand_q      <= 4'd0;
            deb_cnt_q   <= 4'd0;
            rel_cnt_q   <= 4'd0;
            posicion_q  <= 4'd0;
            opr_q       <= 1'b0;
            key_pulse_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            fila_m_q    <= fila;
            fila_s_q    <= fila_m_q;
            div_cnt_q   <= tick ? '0 : div_cnt_q + DIV_W'(1);
            key_pulse_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    ST_SCAN: begin
                        if (hit) begin
                            cand_q <= {row_idx, col_idx_q};
                            if (DEBOUNCE_SCANS == 1) begin
                                posicion_q  <= {row_idx, col_idx_q};
                                opr_q       <= 1'b1;
                                key_pulse_q <= 1'b1;
                                rel_cnt_q   <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_q   <= '0;
`endif
                                state_q     <= ST_HELD;
                            end else begin
                                deb_cnt_q <= 4'd1;
                                state_q   <= ST_CONFIRM;
                            end
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= {col_q[2:0], col_q[3]};
                        end
                    end
                    ST_CONFIRM: begin
                        if (hit && row_idx == cand_q[3:2]) begin
                            if (deb_cnt_d >= 4'(DEBOUNCE_SCANS)) begin
                                deb_cnt_q   <= 4'd0;
                                posicion_q  <= cand_q;
                                opr_q       <= 1'b1;
                                key_pulse_q <= 1'b1;
                                rel_cnt_q   <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_q   <= '0;
`endif
                                state_q     <= ST_HELD;
                            end else begin
                                deb_cnt_q <= deb_cnt_d;
                            end
                        end else begin
                            deb_cnt_q <= 4'd0;
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= {col_q[2:0], col_q[3]};
                            state_q   <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        // Column is frozen here, so only rows of the held column are visible.
                        if (cand_down) begin
                            rel_cnt_q <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rel_cnt_q != 4'd0) begin
                                rep_cnt_q <= '0;
                            end else if (rep_cnt_d == REP_W'(REPEAT_SCANS)) begin
                                rep_cnt_q   <= '0;
                                key_pulse_q <= 1'b1;
                            end else begin
                                rep_cnt_q <= rep_cnt_d;
                            end
`endif
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_q <= '0;
`endif
                            if (rel_cnt_d >= 4'(DEBOUNCE_SCANS)) begin
                                rel_cnt_q <= 4'd0;
                                opr_q     <= 1'b0;
                                col_idx_q <= col_idx_q + 2'd1;
                                col_q     <= {col_q[2:0], col_q[3]};
                                state_q   <= ST_SCAN;
                            end else begin
                                rel_cnt_q <= rel_cnt_d;
                            end
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    assign col       = col_q;
    assign posicion  = posicion_q;
    assign opr       = opr_q;
    assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, expected key indices queued per press,
// a monitor pops and checks on every key_pulse.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] posicion;
    logic       opr;
    logic       key_pulse;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pulse_cnt = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_HOLD_PULSES = 4;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2),
        .REPEAT_SCANS  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fila     (fila),
        .col      (col),
        .posicion (posicion),
        .opr      (opr),
        .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        fila = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && col[c] == 1'b0) fila[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_opr(input logic lvl, input string name);
        int n = 0;
        while (opr !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(opr), 32'(lvl));
    endtask

    // Monitor: every press strobe must match the next queued key index.
    always @(negedge clk) begin
        if (key_pulse === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(posicion), 32'hFFFF);
            end else begin
                check("pulse_posicion", 32'(posicion), 32'(exp_q.pop_front()));
                check("pulse_opr", 32'(opr), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [4];
        logic [3:0] prev;
        int         cnt;
        int         p0;
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

        rst = 1'b1;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'hE);
        check("rst_opr", 32'(opr), 32'd0);
        check("rst_pos", 32'(posicion), 32'd0);
        check("rst_pulse", 32'(key_pulse), 32'd0);
        rst = 1'b0;

        // Idle scan: column steps every 4 clocks
        prev = col;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (col == prev && cnt < 20);
            check("scan_col", 32'(col), 32'(seq[k]));
            check("scan_period", 32'(cnt), 32'd4);
            prev = col;
        end
        check("idle_opr", 32'(opr), 32'd0);

        // Clean press key 9 (row 2, column 1)
        p0 = pulse_cnt;
        exp_q.push_back(4'd9);
        pressed[9] = 1'b1;
        wait_opr(1'b1, "k9_press_timeout");
        check("k9_pos", 32'(posicion), 32'd9);
        repeat (12) @(negedge clk);
        check("k9_col_held", 32'(col), 32'hD);
        check("k9_opr_held", 32'(opr), 32'd1);
        pressed[9] = 1'b0;
        wait_opr(1'b0, "k9_release_timeout");
        check("k9_col_resume", 32'(col), 32'hB);
        check("k9_pos_kept", 32'(posicion), 32'd9);
        check("k9_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Bounce on key 3 (row 0, column 3): seen on one tick only
        p0 = pulse_cnt;
        cnt = 0;
        while (col != 4'b0111 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("bounce_col_reach", 32'(col), 32'h7);
        pressed[3] = 1'b1;
        repeat (4) @(negedge clk);
        pressed[3] = 1'b0;
        repeat (5) @(negedge clk);
        check("bounce_col_adv", 32'(col), 32'hE);
        check("bounce_opr", 32'(opr), 32'd0);
        check("bounce_pos", 32'(posicion), 32'd9);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Stable press key 12 (row 3, column 0)
        exp_q.push_back(4'd12);
        pressed[12] = 1'b1;
        wait_opr(1'b1, "k12_press_timeout");
        check("k12_pos", 32'(posicion), 32'd12);
        pressed[12] = 1'b0;
        wait_opr(1'b0, "k12_release_timeout");

        // Rows 1 and 3 on column 0: lowest row wins; other-column press ignored
        exp_q.push_back(4'd4);
        pressed[4] = 1'b1;
        pressed[12] = 1'b1;
        wait_opr(1'b1, "multi_press_timeout");
        check("multi_pos", 32'(posicion), 32'd4);
        pressed[2] = 1'b1;
        repeat (40) @(negedge clk);
        check("other_col_opr", 32'(opr), 32'd1);
        check("other_col_pos", 32'(posicion), 32'd4);
        check("other_col_col", 32'(col), 32'hE);
        pressed = 16'h0;
        wait_opr(1'b0, "multi_release_timeout");

        // Reset while held, then re-acceptance and hold for 10 ticks
        exp_q.push_back(4'd5);
        pressed[5] = 1'b1;
        wait_opr(1'b1, "k5_press_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("held_rst_opr", 32'(opr), 32'd0);
        check("held_rst_pos", 32'(posicion), 32'd0);
        check("held_rst_col", 32'(col), 32'hE);
        p0 = pulse_cnt;
        for (int k = 0; k < EXP_HOLD_PULSES; k++) exp_q.push_back(4'd5);
        wait_opr(1'b1, "k5_reaccept_timeout");
        repeat (40) @(negedge clk);
        check("k5_hold_pulses", 32'(pulse_cnt - p0), 32'(EXP_HOLD_PULSES));
        check("k5_pos", 32'(posicion), 32'd5);
        pressed = 16'h0;
        wait_opr(1'b0, "k5_release_timeout");

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
